// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative mul/div sequencer driving HI/LO write enables and data
module hilo_muldiv_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [1:0]            hi_we,
    output logic [1:0]            lo_we,
    output logic [DATA_WIDTH-1:0] hi_wdata,
    output logic [DATA_WIDTH-1:0] lo_wdata
);
    localparam int W = DATA_WIDTH;
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, WRITE} state_t;
    state_t state;
    logic [W-1:0] acc_hi, acc_lo, opnd, rs_abs, rt_abs, diff, fix_hi, fix_lo;
    logic [CNT_WIDTH-1:0] cnt;
    logic is_div, neg_p, neg_r, zero_div, sgn_op, ge;
    logic [W:0] add_sum, shifted;
    logic [2*W-1:0] prod_neg;
    assign busy = state != IDLE;
    // acc_hi doubles as multiply high half / divide remainder; acc_lo as multiplier / quotient
    always_comb begin
        sgn_op   = ~op[0];
        rs_abs   = (sgn_op && rs_data[W-1]) ? -rs_data : rs_data;
        rt_abs   = (sgn_op && rt_data[W-1]) ? -rt_data : rt_data;
        add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        shifted  = {acc_hi, acc_lo[W-1]};
        ge       = shifted >= {1'b0, opnd};
        diff     = shifted[W-1:0] - opnd;
        prod_neg = -{acc_hi, acc_lo};
        fix_hi   = is_div ? (neg_r ? -acc_hi : acc_hi) : (neg_p ? prod_neg[2*W-1:W] : acc_hi);
        fix_lo   = neg_p ? (is_div ? -acc_lo : prod_neg[W-1:0]) : acc_lo;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            neg_p       <= 1'b0;
            neg_r       <= 1'b0;
            zero_div    <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi_we       <= 2'b00;
            lo_we       <= 2'b00;
            hi_wdata    <= '0;
            lo_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !op[2]) begin
                        is_div   <= op[1];
                        neg_p    <= sgn_op & (rs_data[W-1] ^ rt_data[W-1]);
                        neg_r    <= sgn_op & rs_data[W-1];
                        zero_div <= op[1] && rt_data == '0;
                        acc_hi   <= '0;
                        acc_lo   <= op[1] ? rs_abs : rt_abs;
                        opnd     <= op[1] ? rt_abs : rs_abs;
                        cnt      <= '0;
                        state    <= CALC;
                    end else if (start && op[2:1] == 2'b10) begin
                        hi_wdata <= rs_data;
                        lo_wdata <= rs_data;
                        hi_we    <= {2{~op[0]}};
                        lo_we    <= {2{op[0]}};
                        done     <= 1'b1;
                        state    <= WRITE;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc_hi <= ge ? diff : shifted[W-1:0];
                        acc_lo <= {acc_lo[W-2:0], ge};
                    end else begin
                        {acc_hi, acc_lo} <= {add_sum, acc_lo[W-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_WIDTH'(W - 1))
                        state <= FIXUP;
                end
                FIXUP: begin
                    hi_wdata    <= fix_hi;
                    lo_wdata    <= fix_lo;
                    hi_we       <= zero_div ? 2'b00 : 2'b11;
                    lo_we       <= zero_div ? 2'b00 : 2'b11;
                    div_by_zero <= zero_div;
                    done        <= 1'b1;
                    state       <= WRITE;
                end
                default: begin
                    hi_we       <= 2'b00;
                    lo_we       <= 2'b00;
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
